onchip_mem_arbiter: RTL and testbench

//   Two-master Avalon-MM arbiter and sequencer in front of the single-port on-chip RAM (32-bit words, byte enables).

---
 rtl/onchip_mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : onchip_mem_arbiter
//  Description : Two-master Avalon-MM arbiter and sequencer in front of a
//                single-port on-chip RAM (32-bit words, byte enables).
//                Round-robin sharing of the one RAM port, one command per
//                cycle, fixed read latency of three edges from acceptance.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset_n          clock (rising edge) / asynchronous active-low reset
//    pause                 1 = no new grants; in-flight reads still complete
//    m{0,1}_address        word address from master N
//    m{0,1}_byteenable     write byte lanes (ignored on reads)
//    m{0,1}_read/_write    request strobes (read+write together = write)
//    m{0,1}_writedata      write data
//    m{0,1}_waitrequest    1 = request not accepted this cycle
//    m{0,1}_readdata       read data, qualified by readdatavalid
//    m{0,1}_readdatavalid  one-cycle strobe per accepted read
//    mem_*                 registered command to the RAM s1 port
//    mem_clken             RAM clock enable, 1 from the first edge after reset
//    mem_readdata          RAM q (address registered inside the RAM)
//    oor_count             saturating count of out-of-range requests
// ============================================================================
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int NUM_WORDS = 32896
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pause,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM side
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [7:0]        oor_count
);

  localparam logic [31:0] c_num_words = 32'(NUM_WORDS);
  localparam logic [7:0]  c_oor_max   = 8'hFF;

  // Read-pipeline tag: one entry per accepted read travelling towards the
  // cycle in which the RAM q is valid.
  typedef struct packed {
    logic valid;  // an accepted read occupies this slot
    logic owner;  // 0 = m0, 1 = m1
    logic oor;    // address was out of range: return zero, RAM not accessed
  } rd_tag_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic              clken_q;
  logic              last_grant_q,  last_grant_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [BE_W-1:0]   mem_be_q,      mem_be_d;
  logic              mem_cs_q,      mem_cs_d;
  logic              mem_we_q,      mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic [7:0]        oor_cnt_q,     oor_cnt_d;
  rd_tag_t           tag1_q,        tag1_d;
  rd_tag_t           tag2_q,        tag2_d;
  logic [DATA_W-1:0] rd0_q,         rd0_d;
  logic [DATA_W-1:0] rd1_q,         rd1_d;
  logic              rdv0_q,        rdv0_d;
  logic              rdv1_q,        rdv1_d;

  // --------------------------------------------------------------------------
  // Arbitration (combinational, same cycle as the request)
  // --------------------------------------------------------------------------
  logic              w_req0, w_req1;
  logic              w_grant0, w_grant1;
  logic              w_accept;
  logic              w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic              w_is_wr;
  logic              w_oor;
  logic [DATA_W-1:0] w_rdata;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // clken_q is cleared asynchronously by reset and only rises on the first
  // edge after release, so it doubles as the "arbiter is running" qualifier.
  // With both masters requesting, the one not served last wins; last_grant_q
  // resets to 1 so that m0 wins the first contention.
  assign w_grant0 = clken_q & ~pause & w_req0 & (~w_req1 |  last_grant_q);
  assign w_grant1 = clken_q & ~pause & w_req1 & (~w_req0 | ~last_grant_q);

  assign m0_waitrequest = w_req0 & ~w_grant0;
  assign m1_waitrequest = w_req1 & ~w_grant1;

  assign w_accept = w_grant0 | w_grant1;
  assign w_sel    = w_grant1;

  assign w_addr  = w_sel ? m1_address    : m0_address;
  assign w_be    = w_sel ? m1_byteenable : m0_byteenable;
  assign w_wdata = w_sel ? m1_writedata  : m0_writedata;
  // A request with both strobes set is a write.
  assign w_is_wr = w_sel ? m1_write      : m0_write;

  assign w_oor = ({{(32-ADDR_W){1'b0}}, w_addr} >= c_num_words);

  // Out-of-range reads never touched the RAM, so substitute zero for its q.
  assign w_rdata = tag2_q.oor ? '0 : mem_readdata;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    mem_cs_d     = 1'b0;
    mem_we_d     = 1'b0;
    oor_cnt_d    = oor_cnt_q;
    tag1_d       = '0;
    tag2_d       = tag1_q;
    rd0_d        = rd0_q;
    rd1_d        = rd1_q;
    rdv0_d       = 1'b0;
    rdv1_d       = 1'b0;

    // Command stage: the accepted request becomes next cycle's RAM command.
    // Out-of-range requests still consume the slot but keep chipselect low
    // so the RAM is neither written nor re-addressed.
    if (w_accept) begin
      last_grant_d = w_sel;
      mem_addr_d   = w_addr;
      mem_be_d     = w_be;
      mem_wdata_d  = w_wdata;
      mem_cs_d     = ~w_oor;
      mem_we_d     = w_is_wr & ~w_oor;
      tag1_d.valid = ~w_is_wr;
      tag1_d.owner = w_sel;
      tag1_d.oor   = w_oor;
      if (w_oor && (oor_cnt_q != c_oor_max)) begin
        oor_cnt_d = oor_cnt_q + 8'd1;
      end
    end

    // Response stage: the RAM latched the address one edge after the command
    // was issued, so its q is valid now for the read tagged in stage 2. Only
    // the owner's readdata register is loaded; the other holds its value.
    if (tag2_q.valid) begin
      if (tag2_q.owner) begin
        rd1_d  = w_rdata;
        rdv1_d = 1'b1;
      end else begin
        rd0_d  = w_rdata;
        rdv0_d = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clken_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      oor_cnt_q    <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
      rdv0_q       <= 1'b0;
      rdv1_q       <= 1'b0;
    end else begin
      clken_q      <= 1'b1;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      oor_cnt_q    <= oor_cnt_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
      rdv0_q       <= rdv0_d;
      rdv1_q       <= rdv1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_address      = mem_addr_q;
  assign mem_byteenable   = mem_be_q;
  assign mem_chipselect   = mem_cs_q;
  assign mem_write        = mem_we_q;
  assign mem_writedata    = mem_wdata_q;
  assign mem_clken        = clken_q;
  assign oor_count        = oor_cnt_q;
  assign m0_readdata      = rd0_q;
  assign m1_readdata      = rd1_q;
  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_onchip_mem_arbiter
//  Description : Self-checking bench for onchip_mem_arbiter. A behavioural
//                RAM sits on the mem_* port; a transaction-level model
//                (sequential memory image + response queue) predicts every
//                output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_onchip_mem_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int NUM_WORDS = 32896;
  localparam int VW        = 79;

  logic              clk;
  logic              reset_n;
  logic              pause;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m1_read, m0_write, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  logic [7:0]        oor_count;

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .NUM_WORDS(NUM_WORDS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pause(pause),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .oor_count(oor_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: address registered, q unregistered.
  logic [DATA_W-1:0] ram [NUM_WORDS];
  logic [ADDR_W-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Reference model state
  typedef struct {
    int          owner;
    logic [31:0] data;
    int          due;
  } resp_t;

  logic [31:0] exp_mem [NUM_WORDS];
  resp_t       rq[$];
  bit          m_ready;
  bit          m_last;     // 1 = m1 was served last
  bit          m_cs, m_we;
  logic [7:0]  m_oor;
  logic [31:0] m_rd [2];
  int          cyc;
  int          npass, ntot;
  logic [VW-1:0] e, a;

  function automatic void model_clear();
    rq.delete();
    m_ready = 0;
    m_last  = 1;
    m_cs    = 0;
    m_we    = 0;
    m_oor   = 8'd0;
    m_rd[0] = 32'd0;
    m_rd[1] = 32'd0;
  endfunction

  task automatic drive(input int m, input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 16'd0, 4'h0, 32'd0);
    drive(1, 0, 0, 16'd0, 4'h0, 32'd0);
    pause = 1'b0;
  endtask

  // One clock: predict and sample outputs at the falling edge, then advance
  // the model with whatever the rules say is accepted at the rising edge.
  task automatic tick(output logic [VW-1:0] ev, output logic [VW-1:0] av);
    bit r0, r1, g0, g1, v0, v1, oor, wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    resp_t       r;
    @(negedge clk);
    r0 = m0_read || m0_write;
    r1 = m1_read || m1_write;
    g0 = 0; g1 = 0;
    if (reset_n && m_ready && !pause) begin
      if (r0 && r1) begin g0 = m_last; g1 = !m_last; end
      else begin g0 = r0; g1 = r1; end
    end
    v0 = 0; v1 = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.owner == 0) begin v0 = 1; m_rd[0] = r.data; end
      else begin v1 = 1; m_rd[1] = r.data; end
    end
    ev = {r0 && !g0, r1 && !g1, v0, v1, m_rd[0], m_rd[1], m_cs, m_we, m_ready, m_oor};
    av = {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
          m0_readdata, m1_readdata, mem_chipselect, mem_write, mem_clken, oor_count};
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      model_clear();
    end else begin
      m_cs = 0; m_we = 0;
      if (g0 || g1) begin
        addr = g1 ? m1_address    : m0_address;
        wr   = g1 ? m1_write      : m0_write;
        be   = g1 ? m1_byteenable : m0_byteenable;
        wd   = g1 ? m1_writedata  : m0_writedata;
        oor  = (int'(addr) >= NUM_WORDS);
        m_last = g1;
        if (oor && m_oor != 8'hFF) m_oor++;
        if (wr) begin
          if (!oor) begin
            for (int b = 0; b < 4; b++) if (be[b]) exp_mem[addr][8*b +: 8] = wd[8*b +: 8];
            m_cs = 1; m_we = 1;
          end
        end else begin
          m_cs    = !oor;
          r.owner = g1 ? 1 : 0;
          r.data  = oor ? 32'd0 : exp_mem[addr];
          r.due   = cyc + 2;
          rq.push_back(r);
        end
      end
      m_ready = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    model_clear();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) reset_n = 1'b1;
      if (i == 3) drive(0, 1, 0, 16'd5, 4'hF, 32'd0);
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL reset cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
    idle();
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 0) drive(0, 0, 1, 16'h0010, 4'hF, 32'hDEADBEEF);
      if (i == 1) drive(0, 1, 0, 16'h0010, 4'hF, 32'd0);
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL write_read cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
    ntot++;
    if (m0_readdata !== 32'hDEADBEEF) $display("FAIL write_read_data got=%h want=deadbeef", m0_readdata);
    else npass++;
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 16; i++) begin
      idle();
      if (i < 12) begin
        drive(0, 1, 0, 16'(i), 4'hF, 32'd0);
        drive(1, 1, 0, 16'h0010, 4'hF, 32'd0);
      end
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL alternate cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
  endtask

  task automatic test_byte_enable();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 0) drive(0, 0, 1, 16'h0020, 4'hF, 32'h11223344);
      if (i == 1) drive(0, 0, 1, 16'h0020, 4'h2, 32'h0000AA00);
      if (i == 2) drive(0, 1, 0, 16'h0020, 4'h0, 32'd0);
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL byte_enable cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
    ntot++;
    if (m0_readdata !== 32'h1122AA44) $display("FAIL byte_enable_data got=%h want=1122aa44", m0_readdata);
    else npass++;
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 0) drive(1, 1, 0, 16'h8080, 4'hF, 32'd0);
      if (i == 1) drive(1, 0, 1, 16'hFFFF, 4'hF, 32'hFFFFFFFF);
      if (i == 2) drive(0, 0, 1, 16'h807F, 4'hF, 32'hCAFEF00D);
      if (i == 3) drive(0, 1, 0, 16'h807F, 4'hF, 32'd0);
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL out_of_range cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
    ntot++;
    if (oor_count !== 8'd2 || m1_readdata !== 32'd0)
      $display("FAIL oor_count got=%0d/%h want=2/00000000", oor_count, m1_readdata);
    else npass++;
  endtask

  task automatic test_pause();
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i == 0) drive(0, 1, 0, 16'h0010, 4'hF, 32'd0);
      if (i >= 1 && i <= 3) begin
        pause = 1'b1;
        drive(0, 1, 0, 16'h0020, 4'hF, 32'd0);
        drive(1, 0, 1, 16'h0030, 4'hF, 32'h55AA55AA);
      end
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL pause cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 0 || i == 3 || i == 4) drive(0, 1, 0, 16'h0020, 4'hF, 32'd0);
      if (i == 2) begin reset_n = 1'b0; model_clear(); end
      if (i == 3) reset_n = 1'b1;
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL reset_midop cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
    ntot++;
    if (m0_readdata !== 32'h1122AA44) $display("FAIL reset_midop_data got=%h want=1122aa44", m0_readdata);
    else npass++;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] ad;
    case ($urandom_range(0, 9))
      0:       ad = 16'd32895;
      1:       ad = 16'd32896;
      2:       ad = 16'hFFFF;
      default: ad = 16'($urandom_range(0, 7));
    endcase
    return ad;
  endfunction

  task automatic test_random();
    int k;
    for (int i = 0; i < 405; i++) begin
      idle();
      if (i < 400) begin
        for (int m = 0; m < 2; m++) begin
          k = $urandom_range(0, 3);
          drive(m, k[0], k[1], rand_addr(), 4'($urandom_range(0, 15)), $urandom);
        end
        pause = ($urandom_range(0, 7) == 0);
      end
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL random cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
  endtask

  task automatic test_oor_saturate();
    for (int i = 0; i < 262; i++) begin
      idle();
      if (i < 260) drive(0, 0, 1, 16'hFFFF, 4'hF, 32'h0);
      tick(e, a);
      ntot++;
      if (a !== e) $display("FAIL oor_saturate cyc=%0d got=%h want=%h", cyc, a, e);
      else npass++;
    end
    ntot++;
    if (oor_count !== 8'hFF) $display("FAIL oor_saturate_count got=%0d want=255", oor_count);
    else npass++;
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    cyc   = 0;
    ram_addr_q = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      ram[i]     = 32'd0;
      exp_mem[i] = 32'd0;
    end
    test_reset();
    test_write_read();
    test_alternate();
    test_byte_enable();
    test_out_of_range();
    test_pause();
    test_reset_midop();
    test_random();
    test_oor_saturate();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
